// File: rtl/lbuff_pkg.sv
// Shared types, default geometry and helpers for the VGA line-buffer scheduler.
// Optional statistics are enabled by defining LBUFF_SCHED_STATS_EN.
package lbuff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PREFILL_A = 2'd1,
        ST_PREFILL_B = 2'd2,
        ST_ACTIVE    = 2'd3
    } lbuff_sched_state_t;

    localparam int DEF_WIDTH_PX    = 640;
    localparam int DEF_HEIGHT_PX   = 480;
    localparam int DEF_TILE_WIDTH  = 4;
    localparam int DEF_TILE_HEIGHT = 4;

    function automatic logic [1:0] onehot2(input logic idx);
        if (idx) begin
            return 2'b10;
        end else begin
            return 2'b01;
        end
    endfunction

endpackage

// File: rtl/line_buff_sched_tile_row_end_det.sv
// Tile-row end detector: one-cycle strobe on the active-video falling edge of
// the last pixel line of a tile row.
module tile_row_end_det
    import lbuff_pkg::*;
#(
    parameter int TILE_HEIGHT   = DEF_TILE_HEIGHT,
    parameter int PXL_CTR_WIDTH = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     disp_en_i,
    input  logic [PXL_CTR_WIDTH-1:0] pxl_y_i,
    output logic                     row_end_o
);

    localparam logic [PXL_CTR_WIDTH-1:0] PHASE_MASK = PXL_CTR_WIDTH'(TILE_HEIGHT - 1);

    logic disp_en_q;
    logic disp_en_d;

    // Next value of the delayed active-video flag
    always_comb begin
        disp_en_d = disp_en_i;
    end

    // Delayed active-video flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            disp_en_q <= 1'b0;
        end else begin
            disp_en_q <= disp_en_d;
        end
    end

    // The line number is still that of the line just finished at the falling edge
    always_comb begin
        row_end_o = disp_en_q & ~disp_en_i & ((pxl_y_i & PHASE_MASK) == PHASE_MASK);
    end

endmodule

// File: rtl/line_buff_sched.sv
// Ping-pong line buffer scheduler: prefill, display select, in-order refills.
// Define LBUFF_SCHED_STATS_EN to add the saturating underrun_cnt_o counter.
module line_buff_sched
    import lbuff_pkg::*;
#(
    parameter int WIDTH_PX       = DEF_WIDTH_PX,
    parameter int HEIGHT_PX      = DEF_HEIGHT_PX,
    parameter int TILE_WIDTH     = DEF_TILE_WIDTH,
    parameter int TILE_HEIGHT    = DEF_TILE_HEIGHT,
    parameter int TILE_ROWS      = HEIGHT_PX / TILE_HEIGHT,
    parameter int TILE_CTR_WIDTH = $clog2(WIDTH_PX / TILE_WIDTH),
    parameter int PXL_CTR_WIDTH  = 10
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      frame_start_i,
    input  logic                      disp_en_i,
    input  logic [PXL_CTR_WIDTH-1:0]  pxl_x_i,
    input  logic [PXL_CTR_WIDTH-1:0]  pxl_y_i,
    input  logic [1:0]                buff_fill_done_i,
    output logic [1:0]                buff_fill_req_o,
    output logic [1:0]                buff_sel_o,
    output logic [TILE_CTR_WIDTH-1:0] disp_pxl_id_o,
    output logic                      underrun_o,
    output logic                      busy_o
`ifdef LBUFF_SCHED_STATS_EN
    ,
    output logic [7:0]                underrun_cnt_o
`endif
);

    localparam int RW         = $clog2(TILE_ROWS + 1);
    localparam int TILE_W_LOG = $clog2(TILE_WIDTH);
    localparam logic [RW-1:0] ROWS_L     = RW'(TILE_ROWS);
    localparam logic [RW-1:0] LAST_ROW_L = RW'(TILE_ROWS - 1);
    localparam logic [RW-1:0] TWO_L      = RW'(2);
    localparam logic [RW-1:0] ONE_L      = RW'(1);

    lbuff_sched_state_t state_q, state_d;
    logic [1:0]         req_q, req_d;
    logic [1:0]         sel_q, sel_d;
    logic [1:0]         pend_q, pend_d;
    logic               disp_q, disp_d;
    logic [RW-1:0]      fill_q, fill_d;
    logic [RW-1:0]      row_q, row_d;
    logic               und_q, und_d;
    logic               busy_q, busy_d;
    logic               und_evt_s;
    logic               row_end_s;
    logic [PXL_CTR_WIDTH-1:0] x_tile_s;

    tile_row_end_det #(
        .TILE_HEIGHT   (TILE_HEIGHT),
        .PXL_CTR_WIDTH (PXL_CTR_WIDTH)
    ) u_row_end (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .disp_en_i (disp_en_i),
        .pxl_y_i   (pxl_y_i),
        .row_end_o (row_end_s)
    );

    // Next-state, request, select and underrun logic
    always_comb begin
        state_d   = state_q;
        req_d     = 2'b00;
        sel_d     = sel_q;
        disp_d    = disp_q;
        fill_d    = fill_q;
        row_d     = row_q;
        pend_d    = pend_q & ~buff_fill_done_i;
        und_evt_s = 1'b0;

        if (frame_start_i && (state_q != ST_IDLE)) begin
            und_evt_s = 1'b1;
        end else begin
            und_evt_s = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                sel_d = 2'b00;
                if (frame_start_i) begin
                    state_d   = ST_PREFILL_A;
                    row_d     = {RW{1'b0}};
                    fill_d    = {RW{1'b0}};
                    req_d     = 2'b01;
                    pend_d[0] = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PREFILL_A: begin
                if (buff_fill_done_i[0] && pend_q[0]) begin
                    state_d   = ST_PREFILL_B;
                    req_d     = 2'b10;
                    pend_d[1] = 1'b1;
                end else begin
                    state_d = ST_PREFILL_A;
                end
            end
            ST_PREFILL_B: begin
                if (buff_fill_done_i[1] && pend_q[1]) begin
                    state_d = ST_ACTIVE;
                    disp_d  = 1'b0;
                    fill_d  = TWO_L;
                    sel_d   = onehot2(1'b0);
                end else begin
                    state_d = ST_PREFILL_B;
                end
            end
            ST_ACTIVE: begin
                if (!row_end_s) begin
                    state_d = ST_ACTIVE;
                end else if (row_q == LAST_ROW_L) begin
                    state_d = ST_IDLE;
                    row_d   = row_q + ONE_L;
                    sel_d   = 2'b00;
                end else begin
                    row_d  = row_q + ONE_L;
                    disp_d = ~disp_q;
                    sel_d  = onehot2(~disp_q);
                    // The swap goes ahead even when the incoming buffer is late
                    if (pend_d[~disp_q]) begin
                        und_evt_s = 1'b1;
                    end else begin
                        und_evt_s = und_evt_s;
                    end
                    if (fill_q < ROWS_L) begin
                        req_d          = onehot2(disp_q);
                        pend_d[disp_q] = 1'b1;
                        fill_d         = fill_q + ONE_L;
                    end else begin
                        fill_d = fill_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = 2'b00;
            end
        endcase

        und_d  = und_q | und_evt_s;
        busy_d = (state_d != ST_IDLE);
    end

    // Scheduler state and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            req_q   <= 2'b00;
            sel_q   <= 2'b00;
            pend_q  <= 2'b00;
            disp_q  <= 1'b0;
            fill_q  <= {RW{1'b0}};
            row_q   <= {RW{1'b0}};
            und_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            sel_q   <= sel_d;
            pend_q  <= pend_d;
            disp_q  <= disp_d;
            fill_q  <= fill_d;
            row_q   <= row_d;
            und_q   <= und_d;
            busy_q  <= busy_d;
        end
    end

    // Tile index for readout, forced to zero outside active video
    always_comb begin
        x_tile_s = pxl_x_i >> TILE_W_LOG;
        if (disp_en_i) begin
            disp_pxl_id_o = x_tile_s[TILE_CTR_WIDTH-1:0];
        end else begin
            disp_pxl_id_o = {TILE_CTR_WIDTH{1'b0}};
        end
    end

    assign buff_fill_req_o = req_q;
    assign buff_sel_o      = sel_q;
    assign underrun_o      = und_q;
    assign busy_o          = busy_q;

`ifdef LBUFF_SCHED_STATS_EN
    logic [7:0] cnt_q, cnt_d;

    // Saturating underrun event counter
    always_comb begin
        if (und_evt_s && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Underrun counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign underrun_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_line_buff_sched.sv
// Self-checking bench for line_buff_sched (16-line frame, 4x4 tiles); honours
// LBUFF_SCHED_STATS_EN for the optional underrun counter.
module tb_line_buff_sched;

    localparam int TILE_WIDTH  = 4;
    localparam int TILE_HEIGHT = 4;
    localparam int HEIGHT_PX   = 16;
    localparam int ROWS        = HEIGHT_PX / TILE_HEIGHT;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       frame_start_i = 1'b0;
    logic       disp_en_i = 1'b0;
    logic [9:0] pxl_x_i = 10'd0;
    logic [9:0] pxl_y_i = 10'd0;
    logic [1:0] buff_fill_done_i = 2'b00;
    logic [1:0] buff_fill_req_o;
    logic [1:0] buff_sel_o;
    logic [7:0] disp_pxl_id_o;
    logic       underrun_o;
    logic       busy_o;
`ifdef LBUFF_SCHED_STATS_EN
    logic [7:0] underrun_cnt_o;
`endif

    line_buff_sched #(
        .WIDTH_PX    (640),
        .HEIGHT_PX   (HEIGHT_PX),
        .TILE_WIDTH  (TILE_WIDTH),
        .TILE_HEIGHT (TILE_HEIGHT)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .frame_start_i    (frame_start_i),
        .disp_en_i        (disp_en_i),
        .pxl_x_i          (pxl_x_i),
        .pxl_y_i          (pxl_y_i),
        .buff_fill_done_i (buff_fill_done_i),
        .buff_fill_req_o  (buff_fill_req_o),
        .buff_sel_o       (buff_sel_o),
        .disp_pxl_id_o    (disp_pxl_id_o),
        .underrun_o       (underrun_o),
        .busy_o           (busy_o)
`ifdef LBUFF_SCHED_STATS_EN
        ,
        .underrun_cnt_o   (underrun_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    // model of the frame: fill k goes to buffer k%2, tile row r shows buffer r%2
    int         m_ph = 0;
    int         m_row = 0;
    int         m_fills = 0;
    logic [1:0] m_pend = 2'b00;
    logic       m_und = 1'b0;
    int         m_cnt = 0;
    logic       m_prev_en = 1'b0;
    logic [1:0] e_req = 2'b00;
    logic [1:0] e_sel = 2'b00;
    logic       e_busy = 1'b0;

    int         req_seen = 0;
    logic [7:0] req_hist = 8'h00;
    logic [7:0] sel_hist = 8'h00;
    logic [1:0] prev_sel = 2'b00;

    int         resp_delay = 1;
    logic [1:0] resp_mask = 2'b11;
    logic       stray1 = 1'b0;
    int         cd [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [1:0] acc;
        logic       re;
        logic       evt;
        int         nb;
        if (rst_i) begin
            m_ph = 0; m_row = 0; m_fills = 0; m_pend = 2'b00; m_und = 1'b0;
            m_cnt = 0; m_prev_en = 1'b0; e_req = 2'b00; e_sel = 2'b00; e_busy = 1'b0;
            return;
        end
        re = m_prev_en && !disp_en_i && ((pxl_y_i % TILE_HEIGHT) == TILE_HEIGHT - 1);
        m_prev_en = disp_en_i;
        acc = buff_fill_done_i & m_pend;
        m_pend = m_pend & ~buff_fill_done_i;
        e_req = 2'b00;
        evt = frame_start_i && (m_ph != 0);
        case (m_ph)
            0: begin
                e_sel = 2'b00;
                if (frame_start_i) begin
                    m_ph = 1; m_row = 0; m_fills = 1; e_req = 2'b01; m_pend[0] = 1'b1;
                end
            end
            1: if (acc[0]) begin
                m_ph = 2; m_fills = 2; e_req = 2'b10; m_pend[1] = 1'b1;
            end
            2: if (acc[1]) begin
                m_ph = 3; m_row = 0; e_sel = 2'b01;
            end
            default: if (re) begin
                if (m_row == ROWS - 1) begin
                    m_ph = 0; e_sel = 2'b00;
                end else begin
                    m_row++;
                    nb = m_row % 2;
                    e_sel = (nb == 0) ? 2'b01 : 2'b10;
                    if (m_pend[nb]) evt = 1'b1;
                    if (m_fills < ROWS) begin
                        e_req = (m_fills % 2 == 0) ? 2'b01 : 2'b10;
                        m_pend[m_fills % 2] = 1'b1;
                        m_fills++;
                    end
                end
            end
        endcase
        if (evt) begin
            m_und = 1'b1;
            if (m_cnt < 255) m_cnt++;
        end
        e_busy = (m_ph != 0);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // compare process
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("req", 32'(buff_fill_req_o), 32'(e_req));
            chk("sel", 32'(buff_sel_o), 32'(e_sel));
            chk("busy", 32'(busy_o), 32'(e_busy));
            chk("underrun", 32'(underrun_o), 32'(m_und));
            chk("pxl_id", 32'(disp_pxl_id_o), disp_en_i ? 32'(pxl_x_i / TILE_WIDTH) : 32'd0);
`ifdef LBUFF_SCHED_STATS_EN
            chk("underrun_cnt", 32'(underrun_cnt_o), 32'(m_cnt));
`endif
            if (buff_fill_req_o != 2'b00) begin
                req_seen++;
                req_hist = {req_hist[5:0], buff_fill_req_o};
            end
            if (buff_sel_o != 2'b00 && buff_sel_o != prev_sel) begin
                sel_hist = {sel_hist[5:0], buff_sel_o};
            end
            prev_sel = buff_sel_o;
        end
    end

    // fill datapath stand-in: answers each request after resp_delay cycles
    initial forever begin
        @(posedge clk);
        #2;
        buff_fill_done_i = 2'b00;
        for (int b = 0; b < 2; b++) begin
            if (rst_i) begin
                cd[b] = 0;
            end else begin
                if (cd[b] > 0) begin
                    cd[b]--;
                    if (cd[b] == 0) buff_fill_done_i[b] = 1'b1;
                end
                if (buff_fill_req_o[b] && resp_mask[b]) cd[b] = resp_delay;
            end
        end
        if (stray1) buff_fill_done_i[1] = 1'b1;
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic line(input int y);
        pxl_y_i = 10'(y);
        for (int x = 0; x < 8; x++) begin
            pxl_x_i = 10'(x);
            disp_en_i = 1'b1;
            cyc();
        end
        disp_en_i = 1'b0;
        pxl_x_i = 10'd0;
        cyc(4);
    endtask

    task automatic pulse_fs();
        frame_start_i = 1'b1;
        cyc();
        frame_start_i = 1'b0;
    endtask

    task automatic wait_req(input logic [1:0] v, input string nm);
        int n = 0;
        while (buff_fill_req_o !== v && n < 50) begin
            cyc();
            n++;
        end
        chk(nm, 32'(buff_fill_req_o), 32'(v));
    endtask

    task automatic wait_sel(input logic [1:0] v, input string nm);
        int n = 0;
        while (buff_sel_o !== v && n < 50) begin
            cyc();
            n++;
        end
        chk(nm, 32'(buff_sel_o), 32'(v));
    endtask

    initial begin
        int base;
        cd[0] = 0;
        cd[1] = 0;
        cyc(3);
        chk_en = 1'b1;
        chk("rst_req", 32'(buff_fill_req_o), 32'd0);
        chk("rst_sel", 32'(buff_sel_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_underrun", 32'(underrun_o), 32'd0);
        rst_i = 1'b0;
        cyc(2);

        // prompt fills: full frame
        base = req_seen;
        pulse_fs();
        chk("fs_req01", 32'(buff_fill_req_o), 32'h1);
        wait_req(2'b10, "prefill_b_req10");
        wait_sel(2'b01, "active_sel01");
        chk("active_busy", 32'(busy_o), 32'd1);
        pxl_x_i = 10'd7;
        disp_en_i = 1'b1;
        #1 chk("pxl_id_7", 32'(disp_pxl_id_o), 32'd1);
        disp_en_i = 1'b0;
        #1 chk("pxl_id_blank", 32'(disp_pxl_id_o), 32'd0);
        for (int y = 0; y < HEIGHT_PX; y++) line(y);
        cyc(5);
        chk("frame_req_count", 32'(req_seen - base), 32'd4);
        chk("frame_req_order", 32'(req_hist), 32'h66);
        chk("frame_sel_order", 32'(sel_hist), 32'h66);
        chk("frame_end_sel", 32'(buff_sel_o), 32'd0);
        chk("frame_end_busy", 32'(busy_o), 32'd0);
        chk("frame_end_underrun", 32'(underrun_o), 32'd0);

        // late fill past a tile-row end
        pulse_fs();
        wait_sel(2'b01, "late_sel01");
        for (int y = 0; y < 3; y++) line(y);
        resp_delay = 100;
        for (int y = 3; y < 8; y++) line(y);
        chk("late_underrun", 32'(underrun_o), 32'd1);
        chk("late_swap_sel", 32'(buff_sel_o), 32'h1);
`ifdef LBUFF_SCHED_STATS_EN
        chk("late_cnt", 32'(underrun_cnt_o), 32'd1);
`endif
        for (int y = 8; y < HEIGHT_PX; y++) line(y);
        resp_delay = 1;
        cyc(120);
        chk("late_idle", 32'(busy_o), 32'd0);

        // frame_start while active
        rst_i = 1'b1;
        cyc(2);
        rst_i = 1'b0;
        chk("rst2_underrun", 32'(underrun_o), 32'd0);
        pulse_fs();
        wait_sel(2'b01, "fsact_sel01");
        for (int y = 0; y < 4; y++) line(y);
        pulse_fs();
        chk("fsact_underrun", 32'(underrun_o), 32'd1);
        chk("fsact_busy", 32'(busy_o), 32'd1);
        chk("fsact_sel", 32'(buff_sel_o), 32'h2);

        // reset during PREFILL_B
        rst_i = 1'b1;
        cyc(2);
        rst_i = 1'b0;
        resp_mask = 2'b01;
        pulse_fs();
        wait_req(2'b10, "midrst_req10");
        cyc(2);
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_req", 32'(buff_fill_req_o), 32'd0);
        chk("midrst_sel", 32'(buff_sel_o), 32'd0);
        stray1 = 1'b1;
        cyc();
        stray1 = 1'b0;
        cyc(3);
        chk("stray_busy", 32'(busy_o), 32'd0);
        chk("stray_sel", 32'(buff_sel_o), 32'd0);
        resp_mask = 2'b11;
        pulse_fs();
        chk("restart_req01", 32'(buff_fill_req_o), 32'h1);
        cyc(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
